// File: rtl/fb_pkg.sv
// Shared framebuffer geometry, pixel/command types and the fill FSM encoding.
package fb_pkg;
    localparam int unsigned FB_W      = 320;
    localparam int unsigned FB_H      = 240;
    localparam int unsigned FB_ADDR_W = 17;
    localparam int unsigned COORD_W   = 10;
    localparam int unsigned EXT_W     = 11;

    typedef logic [7:0] rgb332_t;

    typedef struct packed {
        logic [COORD_W-1:0] x0;
        logic [COORD_W-1:0] y0;
        logic [COORD_W-1:0] w;
        logic [COORD_W-1:0] h;
        rgb332_t            color;
    } fill_cmd_t;

    typedef enum logic [1:0] {ST_IDLE, ST_CLIP, ST_FILL, ST_DONE} fill_state_t;

    // Constant multiply built from shifts and adds over the set bits of k.
    function automatic logic [31:0] mul_const(input logic [COORD_W-1:0] v, input int unsigned k);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < 22; i++) begin
            if (k[i]) acc = acc + (32'(v) << i);
        end
        return acc;
    endfunction
endpackage

// File: rtl/rect_fill_engine_if.sv
// Command handshake and framebuffer write port of the rectangle fill engine.
interface rect_fill_engine_if import fb_pkg::*; #(
    parameter int unsigned ADDR_W  = 17,
    parameter int unsigned COLOR_W = 8
);
    logic               cmd_valid;
    logic               cmd_ready;
    logic [COORD_W-1:0] cmd_x0;
    logic [COORD_W-1:0] cmd_y0;
    logic [COORD_W-1:0] cmd_w;
    logic [COORD_W-1:0] cmd_h;
    logic [COLOR_W-1:0] cmd_color;
    logic               fb_gnt;
    logic               fb_wea;
    logic [ADDR_W-1:0]  fb_addra;
    logic [COLOR_W-1:0] fb_dina;
    logic               busy;
    logic               done;

    modport master (
        output cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, fb_gnt,
        input  cmd_ready, fb_wea, fb_addra, fb_dina, busy, done
    );
    modport slave (
        input  cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, fb_gnt,
        output cmd_ready, fb_wea, fb_addra, fb_dina, busy, done
    );
endinterface

// File: rtl/rect_clip.sv
// Clips an accepted fill command to the framebuffer; results are valid the cycle after load.
module rect_clip #(
    parameter int unsigned FB_W   = fb_pkg::FB_W,
    parameter int unsigned FB_H   = fb_pkg::FB_H,
    parameter int unsigned ADDR_W = fb_pkg::FB_ADDR_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load,
    input  fb_pkg::fill_cmd_t          cmd,
    output logic [fb_pkg::COORD_W-1:0] x0,
    output logic [fb_pkg::COORD_W-1:0] y0,
    output logic [fb_pkg::EXT_W-1:0]   x_end,
    output logic [fb_pkg::EXT_W-1:0]   y_end,
    output logic [ADDR_W-1:0]          row_base,
    output logic                       empty,
    output fb_pkg::rgb332_t            color
);
    import fb_pkg::*;

    localparam logic [EXT_W-1:0] W_LIM = EXT_W'(FB_W);
    localparam logic [EXT_W-1:0] H_LIM = EXT_W'(FB_H);

    logic [EXT_W-1:0] x_sum;
    logic [EXT_W-1:0] y_sum;

    assign x_sum = EXT_W'(cmd.x0) + EXT_W'(cmd.w);
    assign y_sum = EXT_W'(cmd.y0) + EXT_W'(cmd.h);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x0       <= '0;
            y0       <= '0;
            x_end    <= '0;
            y_end    <= '0;
            row_base <= '0;
            empty    <= 1'b0;
            color    <= '0;
        end else if (load) begin
            x0       <= cmd.x0;
            y0       <= cmd.y0;
            x_end    <= (x_sum > W_LIM) ? W_LIM : x_sum;
            y_end    <= (y_sum > H_LIM) ? H_LIM : y_sum;
            row_base <= ADDR_W'(mul_const(cmd.y0, FB_W));
            empty    <= (cmd.w == '0) || (cmd.h == '0) ||
                        (EXT_W'(cmd.x0) >= W_LIM) || (EXT_W'(cmd.y0) >= H_LIM);
            color    <= cmd.color;
        end
    end
endmodule

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine: accepts a fill command, clips it, and streams row-major pixel writes.
module rect_fill_engine #(
    parameter int unsigned FB_W    = fb_pkg::FB_W,
    parameter int unsigned FB_H    = fb_pkg::FB_H,
    parameter int unsigned ADDR_W  = fb_pkg::FB_ADDR_W,
    parameter int unsigned COLOR_W = 8
) (
    input logic               clk,
    input logic               reset,
    rect_fill_engine_if.slave bus
);
    import fb_pkg::*;

    fill_state_t        state;
    fill_cmd_t          cmd_in;
    logic               load;
    logic [COORD_W-1:0] clip_x0;
    logic [COORD_W-1:0] clip_y0;
    logic [EXT_W-1:0]   clip_x_end;
    logic [EXT_W-1:0]   clip_y_end;
    logic [ADDR_W-1:0]  clip_row_base;
    logic               clip_empty;
    rgb332_t            clip_color;
    logic [EXT_W-1:0]   x;
    logic [EXT_W-1:0]   y;
    logic [ADDR_W-1:0]  row_base;
    logic               last_col;
    logic               last_row;

    assign cmd_in   = '{x0: bus.cmd_x0, y0: bus.cmd_y0, w: bus.cmd_w, h: bus.cmd_h,
                        color: rgb332_t'(bus.cmd_color)};
    assign load     = (state == ST_IDLE) && bus.cmd_valid && bus.cmd_ready;
    assign last_col = (x == clip_x_end - EXT_W'(1));
    assign last_row = (y == clip_y_end - EXT_W'(1));

    rect_clip #(.FB_W(FB_W), .FB_H(FB_H), .ADDR_W(ADDR_W)) u_clip (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .cmd      (cmd_in),
        .x0       (clip_x0),
        .y0       (clip_y0),
        .x_end    (clip_x_end),
        .y_end    (clip_y_end),
        .row_base (clip_row_base),
        .empty    (clip_empty),
        .color    (clip_color)
    );

    // Outputs are loaded with the values belonging to the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            bus.cmd_ready <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.fb_wea    <= 1'b0;
            bus.fb_addra  <= '0;
            bus.fb_dina   <= '0;
            x             <= '0;
            y             <= '0;
            row_base      <= '0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load) begin
                        state         <= ST_CLIP;
                        bus.cmd_ready <= 1'b0;
                        bus.busy      <= 1'b1;
                    end else begin
                        bus.cmd_ready <= 1'b1;
                    end
                end
                ST_CLIP: begin
                    if (clip_empty) begin
                        state    <= ST_DONE;
                        bus.done <= 1'b1;
                    end else begin
                        state        <= ST_FILL;
                        bus.fb_wea   <= 1'b1;
                        bus.fb_addra <= clip_row_base + ADDR_W'(clip_x0);
                        bus.fb_dina  <= COLOR_W'(clip_color);
                        x            <= EXT_W'(clip_x0);
                        y            <= EXT_W'(clip_y0);
                        row_base     <= clip_row_base;
                    end
                end
                ST_FILL: begin
                    if (bus.fb_gnt) begin
                        if (last_col && last_row) begin
                            state      <= ST_DONE;
                            bus.fb_wea <= 1'b0;
                            bus.done   <= 1'b1;
                        end else if (last_col) begin
                            x            <= EXT_W'(clip_x0);
                            y            <= y + EXT_W'(1);
                            row_base     <= row_base + ADDR_W'(FB_W);
                            bus.fb_addra <= row_base + ADDR_W'(FB_W) + ADDR_W'(clip_x0);
                        end else begin
                            x            <= x + EXT_W'(1);
                            bus.fb_addra <= bus.fb_addra + ADDR_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    state         <= ST_IDLE;
                    bus.busy      <= 1'b0;
                    bus.cmd_ready <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rect_fill_engine.sv
// Randomized and directed bench for rect_fill_engine against a pixel-list reference model.
module tb_rect_fill_engine;
    typedef int unsigned aq_t[$];

    logic clk;
    logic reset;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    rect_fill_engine_if #(.ADDR_W(17), .COLOR_W(8)) bus ();

    rect_fill_engine #(.FB_W(320), .FB_H(240), .ADDR_W(17), .COLOR_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // model state
    aq_t        exp_q;
    logic [7:0] exp_color;
    bit         pending   = 0;
    int         t_acc     = 0;
    int         done_cyc  = -1;
    int         ready_cyc = 1 << 30;
    // observed DUT activity
    aq_t        wlog;
    int         dut_done_cnt = 0;
    int         dut_done_cyc = -1;
    int         first_wr_cyc = -1;
    int         n100         = 0;
    // stimulus control
    int         t_last   = 0;
    int         gnt_mode = 0;
    int         hold_lo  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic aq_t build_q(input int x0, input int y0, input int w, input int h);
        aq_t q;
        int xe;
        int ye;
        xe = (x0 + w < 320) ? x0 + w : 320;
        ye = (y0 + h < 240) ? y0 + h : 240;
        for (int yy = y0; yy < ye; yy++)
            for (int xx = x0; xx < xe; xx++)
                q.push_back(32'(yy * 320 + xx));
        return q;
    endfunction

    // Per-cycle comparison of DUT outputs against the model.
    initial forever begin
        @(negedge clk);
        if (bus.fb_wea && bus.fb_gnt) wlog.push_back(32'(bus.fb_addra));
        if (bus.fb_wea && first_wr_cyc < 0) first_wr_cyc = cyc;
        if (bus.fb_wea && bus.fb_addra == 17'd100) n100++;
        if (bus.done) begin
            dut_done_cnt++;
            dut_done_cyc = cyc;
        end
        if (reset) begin
            check("rst_wea", 32'(bus.fb_wea), 0);
            check("rst_addr", 32'(bus.fb_addra), 0);
            check("rst_data", 32'(bus.fb_dina), 0);
            check("rst_busy", 32'(bus.busy), 0);
            check("rst_done", 32'(bus.done), 0);
            check("rst_ready", 32'(bus.cmd_ready), 0);
            exp_q.delete();
            pending   = 0;
            done_cyc  = -1;
            ready_cyc = cyc + 2;
        end else begin
            bit exp_ready;
            bit exp_wea;
            bit exp_done;
            exp_ready = !pending && (cyc >= ready_cyc);
            exp_done  = pending && (cyc == done_cyc);
            exp_wea   = pending && (cyc >= t_acc + 2) && (exp_q.size() > 0);
            check("cmd_ready", 32'(bus.cmd_ready), 32'(exp_ready));
            check("busy", 32'(bus.busy), 32'(pending));
            check("done", 32'(bus.done), 32'(exp_done));
            check("fb_wea", 32'(bus.fb_wea), 32'(exp_wea));
            if (exp_wea) begin
                check("fb_addra", 32'(bus.fb_addra), exp_q[0]);
                check("fb_dina", 32'(bus.fb_dina), 32'(exp_color));
                if (bus.fb_gnt) begin
                    void'(exp_q.pop_front());
                    if (exp_q.size() == 0) done_cyc = cyc + 1;
                end
            end
            if (exp_done) begin
                pending   = 0;
                ready_cyc = cyc + 1;
            end
            if (exp_ready && bus.cmd_valid) begin
                exp_q     = build_q(int'(bus.cmd_x0), int'(bus.cmd_y0), int'(bus.cmd_w), int'(bus.cmd_h));
                exp_color = bus.cmd_color;
                pending   = 1;
                t_acc     = cyc;
                done_cyc  = (exp_q.size() == 0) ? cyc + 2 : -1;
            end
        end
    end

    // Grant driver: forced-low window, random, or always granted.
    initial begin
        bus.fb_gnt = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (hold_lo > 0) begin
                bus.fb_gnt = 1'b0;
                hold_lo--;
            end else if (gnt_mode != 0) begin
                bus.fb_gnt = 1'($urandom_range(0, 1));
            end else begin
                bus.fb_gnt = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (!bus.cmd_ready) begin
            if (n >= budget) begin
                total++;
                bad++;
                $display("FAIL ready_timeout: got 0 expected 1 within %0d cycles", budget);
                return;
            end
            step();
            n++;
        end
    endtask

    task automatic send(input int x0, input int y0, input int w, input int h, input int col);
        wait_ready(100000);
        bus.cmd_x0    = 10'(x0);
        bus.cmd_y0    = 10'(y0);
        bus.cmd_w     = 10'(w);
        bus.cmd_h     = 10'(h);
        bus.cmd_color = 8'(col);
        bus.cmd_valid = 1'b1;
        t_last        = cyc;
        first_wr_cyc  = -1;
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_wr_addr(input int unsigned a);
        int n;
        n = 0;
        while (!(bus.fb_wea && 32'(bus.fb_addra) == a)) begin
            if (n >= 2000) begin
                total++;
                bad++;
                $display("FAIL addr_timeout: address %0d never presented", a);
                return;
            end
            step();
            n++;
        end
    endtask

    initial begin
        aq_t q;
        int  dc;
        reset         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_x0    = '0;
        bus.cmd_y0    = '0;
        bus.cmd_w     = '0;
        bus.cmd_h     = '0;
        bus.cmd_color = '0;

        // model pins
        q = build_q(10, 10, 2, 2);
        check("model_a_size", 32'(q.size()), 4);
        check("model_a_last", q[3], 3531);
        q = build_q(318, 239, 5, 3);
        check("model_b_size", 32'(q.size()), 2);
        check("model_b_first", q[0], 76798);

        repeat (3) step();
        reset = 1'b0;
        step();
        check("ready_after_reset", 32'(bus.cmd_ready), 1);

        // small square
        wlog.delete();
        send(10, 10, 2, 2, 8'hE0);
        wait_ready(100);
        check("sq_count", 32'(wlog.size()), 4);
        check("sq_w0", wlog[0], 3210);
        check("sq_w1", wlog[1], 3211);
        check("sq_w2", wlog[2], 3530);
        check("sq_w3", wlog[3], 3531);
        check("sq_first_lat", 32'(first_wr_cyc - t_last), 2);
        check("sq_done_lat", 32'(dut_done_cyc - t_last), 6);
        check("sq_interval", 32'(cyc - t_last), 7);

        // clipped at bottom-right corner
        wlog.delete();
        send(318, 239, 5, 3, 8'h1C);
        wait_ready(100);
        check("corner_count", 32'(wlog.size()), 2);
        check("corner_w0", wlog[0], 76798);
        check("corner_w1", wlog[1], 76799);
        check("corner_done_lat", 32'(dut_done_cyc - t_last), 4);

        // empty commands
        wlog.delete();
        send(5, 5, 0, 4, 8'h33);
        wait_ready(100);
        check("w0_done_lat", 32'(dut_done_cyc - t_last), 2);
        check("w0_ready_lat", 32'(cyc - t_last), 3);
        send(320, 0, 4, 4, 8'h44);
        wait_ready(100);
        check("x320_done_lat", 32'(dut_done_cyc - t_last), 2);
        check("x320_ready_lat", 32'(cyc - t_last), 3);
        check("empty_writes", 32'(wlog.size()), 0);

        // randomized commands with random grant
        gnt_mode = 1;
        for (int k = 0; k < 25; k++) begin
            int x0;
            int y0;
            int w;
            int h;
            case ($urandom_range(0, 2))
                0: begin
                    x0 = int'($urandom_range(0, 330)); y0 = int'($urandom_range(0, 250));
                    w  = int'($urandom_range(0, 8));   h  = int'($urandom_range(0, 6));
                end
                1: begin
                    x0 = int'($urandom_range(305, 325)); y0 = int'($urandom_range(225, 245));
                    w  = int'($urandom_range(0, 1023));  h  = int'($urandom_range(0, 1023));
                end
                default: begin
                    x0 = int'($urandom_range(0, 1023)); y0 = int'($urandom_range(0, 1023));
                    w  = int'($urandom_range(0, 4));    h  = int'($urandom_range(0, 4));
                end
            endcase
            send(x0, y0, w, h, int'($urandom_range(0, 255)));
            repeat (int'($urandom_range(0, 3))) step();
        end
        wait_ready(2000);
        gnt_mode = 0;

        // full frame with a grant stall at pixel 100
        wlog.delete();
        n100 = 0;
        send(0, 0, 320, 240, 8'h01);
        wait_wr_addr(100);
        hold_lo = 3;
        wait_ready(90000);
        check("frame_count", 32'(wlog.size()), 76800);
        check("frame_last", wlog[wlog.size() - 1], 76799);
        check("frame_hold100", 32'(n100), 4);

        // reset in the middle of a fill
        wlog.delete();
        send(0, 0, 20, 1, 8'hFF);
        dc = dut_done_cnt;
        wait_wr_addr(4);
        reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;
        check("rst_mid_writes", 32'(wlog.size()), 4);
        check("rst_mid_no_done", 32'(dut_done_cnt), 32'(dc));
        send(3, 4, 3, 2, 8'h55);
        wait_ready(100);
        check("post_rst_writes", 32'(wlog.size()), 10);
        check("post_rst_first", wlog[4], 1283);
        check("post_rst_done", 32'(dut_done_cnt), 32'(dc + 1));

        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rect_fill_engine.md
RECT_FILL_ENGINE -- requirements
Module: rect_fill_engine

Interface
REQ-001 Parameter: FB_W, default 320, framebuffer width in pixels.
REQ-002 Parameter: FB_H, default 240, framebuffer height in pixels.
REQ-003 Parameter: ADDR_W, default 17, framebuffer address width.
REQ-004 Parameter: COLOR_W, default 8, pixel width in RGB332.
REQ-005 Port: clk  in  1  single clock, shared with the framebuffer write port.
REQ-006 Port: reset  in  1  asynchronous, active-high reset.
REQ-007 Port: cmd_valid  in  1  a fill command is present.
REQ-008 Port: cmd_ready  out  1  engine accepts a command.
REQ-009 Port: cmd_x0, cmd_y0  in  10 each  top-left corner, unsigned.
REQ-010 Port: cmd_w, cmd_h  in  10 each  width and height, unsigned.
REQ-011 Port: cmd_color  in  COLOR_W  fill colour.
REQ-012 Port: fb_gnt  in  1  framebuffer write port granted this cycle.
REQ-013 Port: fb_wea  out  1  write enable to framebuffer port A.
REQ-014 Port: fb_addra  out  ADDR_W  write address, y*FB_W + x.
REQ-015 Port: fb_dina  out  COLOR_W  write data.
REQ-016 Port: busy  out  1  a command is in progress (state is not IDLE).
REQ-017 Port: done  out  1  one-cycle pulse when a command completes.

Function
REQ-018 FSM SHALL have states IDLE, CLIP, FILL, DONE; cmd_ready SHALL be 1 only in IDLE.
REQ-019 A command SHALL be accepted on the cycle T where cmd_valid && cmd_ready; all cmd_* fields are latched at T and the FSM goes to CLIP at T+1.
REQ-020 CLIP SHALL compute x_end = min(x0+w, FB_W) and y_end = min(y0+h, FB_H) using 11-bit sums, and row_base = y0*FB_W using shift-add only.
REQ-021 If w==0, h==0, x0>=FB_W or y0>=FB_H, CLIP SHALL go to DONE with no write issued; otherwise it SHALL go to FILL.
REQ-022 In FILL, fb_wea SHALL be 1, fb_addra SHALL equal row_base+x, and fb_dina SHALL equal the latched colour; the first write is presented at T+2.
REQ-023 A pixel is consumed only on a cycle with fb_wea && fb_gnt; while fb_gnt is 0, fb_addra and fb_dina SHALL hold their values.
REQ-024 Pixels SHALL be written in row-major order; on x==x_end-1 the engine SHALL set x=x0, add FB_W to row_base, and increment y, with no multiplier in this path.
REQ-025 The consumed write at (x_end-1, y_end-1) SHALL move the FSM to DONE; done SHALL be 1 for exactly that one DONE cycle, after which the FSM returns to IDLE.
REQ-026 Each command SHALL produce exactly (x_end-x0)*(y_end-y0) consumed writes and SHALL NOT write outside the framebuffer.
REQ-027 The minimum command-to-command interval SHALL be N+3 cycles for N pixels with fb_gnt held at 1.
REQ-028 fb_wea SHALL be 0 in IDLE, CLIP and DONE.

Reset
REQ-029 Reset SHALL force IDLE immediately, including mid-FILL, with no further writes.
REQ-030 During reset: fb_wea=0, fb_addra=0, fb_dina=0, busy=0, done=0, cmd_ready=0.
REQ-031 cmd_ready SHALL be 1 on the first clock edge after reset deasserts.

Structure
REQ-032 A shared package fb_pkg SHALL hold FB_W, FB_H, FB_ADDR_W, the RGB332 pixel typedef, and the fill-command struct typedef.
REQ-033 A single sub-module, rect_clip, SHALL implement the CLIP arithmetic as registered outputs; the FSM and address counters stay in the top module.

Verification
REQ-034 Reset, then release -> all outputs 0 during reset; cmd_ready=1 after release; no fb_wea pulses.
REQ-035 Command (10,10,2,2,0xE0) with fb_gnt=1 -> writes to 3210, 3211, 3530, 3531 on T+2..T+5, each with data 0xE0; done at T+6.
REQ-036 Command (318,239,5,3,0x1C) -> only addresses 76798 and 76799 are written; done follows the second write.
REQ-037 Commands with w=0, and separately with x0=320 -> zero writes; done at T+2; cmd_ready again at T+3.
REQ-038 Command (0,0,320,240,0x01) with fb_gnt low for 3 cycles at pixel 100 -> address 100 held for 4 cycles; 76800 writes total; last address 76799.
REQ-039 Reset asserted at the 5th write of (0,0,20,1,0xFF) -> fb_wea falls with reset; no done pulse; a fresh command after release is accepted normally.
